// File: rtl/chart_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | chart_sequencer: walks a note-chart ROM and emits one-cycle lane pulses   |
// | paced by a speed-scaled beat clock. CHART_LOOP_EN repeats the chart.      |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module chart_sequencer #(
  parameter int ADDR_W = 6,
  parameter int PHASE_W = 24,
  parameter logic [PHASE_W-1:0] BEAT_THRESH = PHASE_W'(781250)
) (
  input  logic              clk,
  input  logic              RST_BTN,
  input  logic              start,
  input  logic              pause,
  input  logic [7:0]        speed,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [3:0]        instr,
  output logic              beat,
  output logic              running,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [3:0]          instr_d;
  logic [3:0]          gap_ld, gap_ld_d;
  logic [3:0]          gap_cnt, gap_cnt_d;
  logic                done_d;
  logic                running_d;
  logic [PHASE_W-1:0]  phase;
  logic [PHASE_W:0]    sum;
  logic [PHASE_W-1:0]  phase_wrap;

  always_ff @(posedge clk or negedge RST_BTN) begin
    if (!RST_BTN) begin
      state    <= S_IDLE;
      rom_addr <= '0;
      instr    <= 4'b0;
      gap_ld   <= 4'b0;
      gap_cnt  <= 4'b0;
      done     <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_d;
      rom_addr <= addr_d;
      instr    <= instr_d;
      gap_ld   <= gap_ld_d;
      gap_cnt  <= gap_cnt_d;
      done     <= done_d;
      running  <= running_d;
    end
  end

  always_comb begin
    state_d   = state;
    addr_d    = rom_addr;
    instr_d   = 4'b0;
    gap_ld_d  = gap_ld;
    gap_cnt_d = gap_cnt;
    done_d    = done;
    if (start) begin
      state_d   = S_FETCH;
      addr_d    = '0;
      gap_cnt_d = 4'b0;
      done_d    = 1'b0;
    end else begin
      case (state)
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          gap_ld_d = rom_data[7:4];
          if (rom_data == 8'h00) begin
`ifdef CHART_LOOP_EN
            addr_d  = '0;
            state_d = S_FETCH;
`else
            done_d  = 1'b1;
            state_d = S_DONE;
`endif
          end else begin
            instr_d = rom_data[3:0];
            state_d = S_EMIT;
          end
        end
        S_EMIT: begin
          gap_cnt_d = (gap_ld == 4'd0) ? 4'd1 : gap_ld;
          state_d   = S_HOLD;
        end
        S_HOLD: begin
          // Only beats seen while holding count; earlier ones are dropped.
          if (beat) begin
            if (gap_cnt <= 4'd1) begin
              gap_cnt_d = 4'd0;
              addr_d    = rom_addr + ADDR_W'(1);
              state_d   = S_FETCH;
            end else begin
              gap_cnt_d = gap_cnt - 4'd1;
            end
          end
        end
        default: state_d = state;
      endcase
    end
    running_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  assign sum        = {1'b0, phase} + {{(PHASE_W-7){1'b0}}, speed};
  assign phase_wrap = sum[PHASE_W-1:0] - BEAT_THRESH;

  always_ff @(posedge clk or negedge RST_BTN) begin
    if (!RST_BTN) begin
      phase <= '0;
      beat  <= 1'b0;
    end else if (start || !running) begin
      phase <= '0;
      beat  <= 1'b0;
    end else if (pause) begin
      beat  <= 1'b0;
    end else if (sum >= {1'b0, BEAT_THRESH}) begin
      phase <= phase_wrap;
      beat  <= 1'b1;
    end else begin
      phase <= sum[PHASE_W-1:0];
      beat  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chart_sequencer.sv
`default_nettype none
// Scoreboard bench for chart_sequencer: directed charts with hand-computed
// pulse cycles, checked by a monitor that pops expectations on each output.
module tb_chart_sequencer;

  logic       clk = 1'b0;
  logic       RST_BTN;
  logic       start;
  logic       pause;
  logic [7:0] speed;
  logic [2:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] instr;
  logic       beat;
  logic       running;
  logic       done;

  chart_sequencer #(
    .ADDR_W(3),
    .PHASE_W(24),
    .BEAT_THRESH(24'd16)
  ) dut (
    .clk(clk),
    .RST_BTN(RST_BTN),
    .start(start),
    .pause(pause),
    .speed(speed),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .instr(instr),
    .beat(beat),
    .running(running),
    .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [8];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int         t;
    logic [3:0] mask;
    logic       is_done;
    logic [2:0] addr;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  logic done_prev = 1'b0;

  task automatic exp_instr(input int t, input logic [3:0] m, input logic [2:0] a);
    ev_t e;
    e.t = t; e.mask = m; e.is_done = 1'b0; e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic exp_done(input int t);
    ev_t e;
    e.t = t; e.mask = 4'b0; e.is_done = 1'b1; e.addr = 3'd0;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!RST_BTN) begin
      done_prev = 1'b0;
    end else begin
      if (instr != 4'b0 || (done && !done_prev)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {27'b0, done, instr}, 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check("evt_cycle", 32'(cyc), 32'(mon_e.t));
          check("evt_is_done", {31'b0, done && !done_prev}, {31'b0, mon_e.is_done});
          if (!mon_e.is_done) begin
            check("evt_mask", {28'b0, instr}, {28'b0, mon_e.mask});
            check("evt_addr", {29'b0, rom_addr}, {29'b0, mon_e.addr});
          end
        end
      end
      done_prev = done;
    end
  end

  task automatic pulse_start(output int t0);
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); n++;
    end
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic rom_fill(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rom[i] = v;
  endtask

  initial begin
    int t0, t1, viol;
    RST_BTN = 1'b0; start = 1'b0; pause = 1'b0; speed = 8'd4;
    rom_fill(8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", {29'b0, rom_addr}, 32'd0);
    check("rst_instr", {28'b0, instr}, 32'd0);
    check("rst_beat", {31'b0, beat}, 32'd0);
    check("rst_running", {31'b0, running}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    RST_BTN = 1'b1;

    viol = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (instr != 4'b0 || beat || running || rom_addr != 3'd0 || done) viol++;
    end
    check("idle_quiet", 32'(viol), 32'd0);

`ifndef CHART_LOOP_EN
    // Basic chart: beats land at start+5,9,13,...
    rom_fill(8'h00);
    rom[0] = 8'h21; rom[1] = 8'h12;
    pulse_start(t0);
    exp_instr(t0 + 3, 4'b0001, 3'd0);
    exp_instr(t0 + 12, 4'b0010, 3'd1);
    exp_done(t0 + 16);
    drain("basic_drain", 40);
    check("basic_running_done", {31'b0, running}, 32'd0);
    check("basic_done_held", {31'b0, done}, 32'd1);

    // Pause during HOLD freezes the phase at 4 for 50 cycles.
    rom_fill(8'h00);
    rom[0] = 8'h31; rom[1] = 8'h04;
    pulse_start(t0);
    exp_instr(t0 + 3, 4'b0001, 3'd0);
    exp_instr(t0 + 66, 4'b0100, 3'd1);
    exp_done(t0 + 70);
    wait_until(t0 + 6);
    pause = 1'b1;
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      if (beat || instr != 4'b0 || rom_addr != 3'd0 || !running) viol++;
      @(posedge clk); #1;
    end
    pause = 1'b0;
    check("pause_frozen", 32'(viol), 32'd0);
    drain("pause_drain", 40);

    // Restart while holding at address 5.
    rom_fill(8'h00);
    for (int i = 0; i < 5; i++) rom[i] = 8'h11;
    rom[5] = 8'h38;
    pulse_start(t0);
    for (int i = 0; i < 5; i++) exp_instr(t0 + ((i == 0) ? 3 : 4 + 4 * i), 4'b0001, 3'(i));
    exp_instr(t0 + 24, 4'b1000, 3'd5);
    wait_until(t0 + 26);
    check("restart_pre_addr", {29'b0, rom_addr}, 32'd5);
    pulse_start(t1);
    check("restart_addr", {29'b0, rom_addr}, 32'd0);
    for (int i = 0; i < 5; i++) exp_instr(t1 + ((i == 0) ? 3 : 4 + 4 * i), 4'b0001, 3'(i));
    exp_instr(t1 + 24, 4'b1000, 3'd5);
    exp_done(t1 + 36);
    drain("restart_drain", 60);
`else
    // Looping chart: end marker at address 1 returns to address 0.
    rom_fill(8'h00);
    rom[0] = 8'h11;
    pulse_start(t0);
    exp_instr(t0 + 3, 4'b0001, 3'd0);
    for (int k = 0; k < 10; k++) exp_instr(t0 + 10 + 8 * k, 4'b0001, 3'd0);
    drain("loop_drain", 120);
    check("loop_done_low", {31'b0, done}, 32'd0);
    check("loop_running", {31'b0, running}, 32'd1);
`endif

    // Gap-zero chart wraps the address, then a mid-chart reset.
    rom_fill(8'h0F);
    pulse_start(t0);
    exp_instr(t0 + 3, 4'b1111, 3'd0);
    for (int i = 1; i < 8; i++) exp_instr(t0 + 4 + 4 * i, 4'b1111, 3'(i));
    exp_instr(t0 + 36, 4'b1111, 3'd0);
    wait_until(t0 + 38);
    check("wrap_pre_reset_addr", {29'b0, rom_addr}, 32'd1);
    RST_BTN = 1'b0;
    #1;
    check("midrst_addr", {29'b0, rom_addr}, 32'd0);
    check("midrst_running", {31'b0, running}, 32'd0);
    check("midrst_instr_beat", {27'b0, beat, instr}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    RST_BTN = 1'b1;
    viol = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (running || beat || instr != 4'b0) viol++;
    end
    check("post_reset_quiet", 32'(viol), 32'd0);
    drain("wrap_drain", 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
